// File: rtl/lmsm_mem_arbiter_if.sv
// lmsm_mem_arbiter_if: MEM-stage, LM/SM burst and data-memory signals of the arbiter
interface lmsm_mem_arbiter_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_stall;
  logic        burst_req;
  logic        burst_we;
  logic [7:0]  burst_mask;
  logic [15:0] burst_base;
  logic [15:0] burst_wdata;
  logic        burst_ack;
  logic [2:0]  burst_idx;
  logic        burst_done;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic        dm_we;
  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, burst_req, burst_we, burst_mask, burst_base, burst_wdata,
    input  mem_stall, burst_ack, burst_idx, burst_done, dm_addr, dm_wdata, dm_we
  );
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, burst_req, burst_we, burst_mask, burst_base, burst_wdata,
    output mem_stall, burst_ack, burst_idx, burst_done, dm_addr, dm_wdata, dm_we
  );
endinterface

// File: rtl/lmsm_mem_arbiter.sv
// lmsm_mem_arbiter: shares the data memory between MEM-stage accesses and atomic LM/SM bursts
module lmsm_mem_arbiter (
  input logic clk,
  input logic reset,
  lmsm_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;
  state_t state;
  logic [7:0] rem_mask;
  logic [15:0] base_q;
  logic we_q;
  logic [2:0] cnt;
  logic [2:0] idx;
  logic last, in_burst, mem_grant, burst_start;
  always_comb begin
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) if (rem_mask[i]) idx = 3'(i);
  end
  assign last = ~|(rem_mask & (rem_mask - 8'd1));
  // Outputs are forced low while reset is high, whatever the state register holds.
  assign in_burst = !reset && state == BURST;
  assign mem_grant = !reset && bus.mem_req && state != BURST;
  assign burst_start = !reset && state == IDLE && bus.burst_req && !bus.mem_req;
  assign bus.mem_stall = !reset && bus.mem_req && state == BURST;
  assign bus.burst_ack = in_burst;
  assign bus.burst_idx = in_burst ? idx : 3'd0;
  assign bus.burst_done = (in_burst && last) || (burst_start && bus.burst_mask == 8'd0);
  assign bus.dm_addr = in_burst ? base_q + {13'd0, cnt} : mem_grant ? bus.mem_addr : 16'd0;
  assign bus.dm_wdata = in_burst ? bus.burst_wdata : mem_grant ? bus.mem_wdata : 16'd0;
  assign bus.dm_we = in_burst ? we_q : mem_grant && bus.mem_we;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rem_mask <= 8'd0;
      base_q <= 16'd0;
      we_q <= 1'b0;
      cnt <= 3'd0;
    end else begin
      case (state)
        IDLE: if (burst_start && bus.burst_mask != 8'd0) begin
          state <= BURST;
          rem_mask <= bus.burst_mask;
          base_q <= bus.burst_base;
          we_q <= bus.burst_we;
          cnt <= 3'd0;
        end
        BURST: begin
          rem_mask <= rem_mask & (rem_mask - 8'd1);
          cnt <= cnt + 3'd1;
          if (last) state <= GAP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lmsm_mem_arbiter.sv
// tb_lmsm_mem_arbiter: directed steps with a per-cycle expected-output scoreboard
module tb_lmsm_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  typedef struct {
    string tag;
    logic stall, ack;
    logic [2:0] idx;
    logic done;
    logic [15:0] addr, wdata;
    logic we;
  } exp_t;
  exp_t sb[$];
  lmsm_mem_arbiter_if ifc();
  lmsm_mem_arbiter dut (.clk(clk), .reset(reset), .bus(ifc));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input string f, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, f, obs, exp);
    end
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, "mem_stall", 16'(ifc.mem_stall), 16'(e.stall));
      chk(e.tag, "burst_ack", 16'(ifc.burst_ack), 16'(e.ack));
      chk(e.tag, "burst_idx", 16'(ifc.burst_idx), 16'(e.idx));
      chk(e.tag, "burst_done", 16'(ifc.burst_done), 16'(e.done));
      chk(e.tag, "dm_addr", ifc.dm_addr, e.addr);
      chk(e.tag, "dm_wdata", ifc.dm_wdata, e.wdata);
      chk(e.tag, "dm_we", 16'(ifc.dm_we), 16'(e.we));
    end
  end
  task automatic drive(input logic mreq, input logic mwe, input logic [15:0] maddr, input logic [15:0] mwdata,
                       input logic breq, input logic bwe, input logic [7:0] bmask, input logic [15:0] bbase,
                       input logic [15:0] bwdata);
    ifc.mem_req = mreq;
    ifc.mem_we = mwe;
    ifc.mem_addr = maddr;
    ifc.mem_wdata = mwdata;
    ifc.burst_req = breq;
    ifc.burst_we = bwe;
    ifc.burst_mask = bmask;
    ifc.burst_base = bbase;
    ifc.burst_wdata = bwdata;
  endtask
  task automatic step(input string tag, input logic stall, input logic ack, input logic [2:0] idx, input logic done,
                      input logic [15:0] addr, input logic [15:0] wdata, input logic we);
    exp_t e;
    e.tag = tag; e.stall = stall; e.ack = ack; e.idx = idx; e.done = done;
    e.addr = addr; e.wdata = wdata; e.we = we;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic quiet(input string tag);
    step(tag, 0, 0, 3'd0, 0, 16'h0000, 16'h0000, 0);
  endtask
  initial begin
    reset = 1'b1;
    drive(1, 1, 16'h1234, 16'h5678, 1, 1, 8'hFF, 16'h0100, 16'h9999);
    @(posedge clk);
    #1;
    // reset dominates requests: everything low
    quiet("rst0");
    quiet("rst1");
    reset = 1'b0;
    drive(0, 0, 16'h0, 16'h0, 0, 0, 8'h00, 16'h0, 16'h0);
    quiet("idle");
    // LM, mask 1010_0100, base 0x0040
    drive(0, 0, 16'h0, 16'h0, 1, 0, 8'hA4, 16'h0040, 16'h0000);
    quiet("lm_grant");
    step("lm_t0", 0, 1, 3'd2, 0, 16'h0040, 16'h0000, 0);
    step("lm_t1", 0, 1, 3'd5, 0, 16'h0041, 16'h0000, 0);
    step("lm_t2", 0, 1, 3'd7, 1, 16'h0042, 16'h0000, 0);
    quiet("lm_gap_req_ignored");
    drive(0, 0, 16'h0, 16'h0, 0, 0, 8'h00, 16'h0, 16'h0);
    quiet("lm_idle");
    // SM, mask FF, base FFFE, MEM contends from the second transfer
    drive(0, 0, 16'h0, 16'h0, 1, 1, 8'hFF, 16'hFFFE, 16'h0);
    quiet("sm_grant");
    for (int k = 0; k < 8; k++) begin
      drive(k >= 1, 1, 16'h0300, 16'hBEEF, 1, 1, 8'hFF, 16'hFFFE, 16'hC000 + 16'(k));
      step($sformatf("sm_t%0d", k), k >= 1, 1, 3'(k), k == 7, 16'hFFFE + 16'(k), 16'hC000 + 16'(k), 1);
    end
    drive(1, 1, 16'h0300, 16'hBEEF, 1, 1, 8'hFF, 16'hFFFE, 16'h0);
    step("sm_gap_mem", 0, 0, 3'd0, 0, 16'h0300, 16'hBEEF, 1);
    drive(0, 0, 16'h0, 16'h0, 0, 0, 8'h00, 16'h0, 16'h0);
    quiet("sm_idle");
    // simultaneous requests: MEM first, burst once MEM drops
    drive(1, 0, 16'h0555, 16'h1111, 1, 1, 8'h03, 16'h0100, 16'h7777);
    step("sim_mem", 0, 0, 3'd0, 0, 16'h0555, 16'h1111, 0);
    drive(0, 0, 16'h0, 16'h0, 1, 1, 8'h03, 16'h0100, 16'h7777);
    quiet("sim_grant");
    step("sim_t0", 0, 1, 3'd0, 0, 16'h0100, 16'h7777, 1);
    ifc.burst_wdata = 16'h8888;
    step("sim_t1", 0, 1, 3'd1, 1, 16'h0101, 16'h8888, 1);
    drive(0, 0, 16'h0, 16'h0, 0, 0, 8'h00, 16'h0, 16'h0);
    quiet("sim_gap");
    // zero mask: immediate done, stays idle
    drive(0, 0, 16'h0, 16'h0, 1, 1, 8'h00, 16'h0500, 16'h4444);
    step("zero_done", 0, 0, 3'd0, 1, 16'h0000, 16'h0000, 0);
    drive(1, 1, 16'h0777, 16'h2222, 0, 0, 8'h00, 16'h0, 16'h0);
    step("zero_idle_mem", 0, 0, 3'd0, 0, 16'h0777, 16'h2222, 1);
    // reset in the middle of a 4-transfer SM burst, then re-issue
    drive(0, 0, 16'h0, 16'h0, 1, 1, 8'h3C, 16'h0200, 16'hAAAA);
    quiet("mid_grant");
    step("mid_t0", 0, 1, 3'd2, 0, 16'h0200, 16'hAAAA, 1);
    step("mid_t1", 0, 1, 3'd3, 0, 16'h0201, 16'hAAAA, 1);
    reset = 1'b1;
    quiet("mid_rst");
    reset = 1'b0;
    quiet("re_grant");
    step("re_t0", 0, 1, 3'd2, 0, 16'h0200, 16'hAAAA, 1);
    step("re_t1", 0, 1, 3'd3, 0, 16'h0201, 16'hAAAA, 1);
    step("re_t2", 0, 1, 3'd4, 0, 16'h0202, 16'hAAAA, 1);
    step("re_t3", 0, 1, 3'd5, 1, 16'h0203, 16'hAAAA, 1);
    drive(0, 0, 16'h0, 16'h0, 0, 0, 8'h00, 16'h0, 16'h0);
    quiet("re_gap");
    @(negedge clk);
    #1;
    chk("end", "scoreboard_left", 16'(sb.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lmsm_mem_arbiter.md
# lmsm_mem_arbiter

Arbiter and sequencer for the single-ported data memory. It shares the memory between two requesters: the MEM pipeline stage, which issues single LW/SW accesses, and the LM/SM burst engine, which issues one access per set bit of an 8-bit register mask at consecutive addresses. The block sits between those two requesters and the data memory address, write-data and write-enable inputs. It grants whole bursts atomically and guarantees the MEM stage one slot after every burst.

## Interface
No parameters: widths are fixed by the ISA at 16-bit data/address and an 8-register mask.

Clock and reset:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high

MEM-stage port:
- mem_req  in  1  single-access request from the MEM stage
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  16  access address
- mem_wdata  in  16  store data
- mem_stall  out  1  MEM access not granted this cycle; the pipeline holds

LM/SM burst port:
- burst_req  in  1  burst request; held high until burst_done
- burst_we  in  1  1 = SM, 0 = LM
- burst_mask  in  8  register mask; bit i selects Ri
- burst_base  in  16  start address
- burst_wdata  in  16  SM store data for the register in burst_idx, supplied combinationally
- burst_ack  out  1  a burst transfer is on the memory this cycle
- burst_idx  out  3  register index of the current transfer
- burst_done  out  1  one-cycle pulse marking the end of a burst

Memory port:
- dm_addr  out  16  memory address
- dm_wdata  out  16  memory write data
- dm_we  out  1  memory write enable

## Operation
- State register values: IDLE, BURST, GAP. Registers: rem_mask[7:0], base_q[15:0], we_q, cnt[2:0].
- IDLE
  - If mem_req is high, MEM is granted: dm_* = mem_addr/mem_wdata/mem_we and mem_stall = 0.
  - The MEM stage wins a simultaneous request. The burst waits in IDLE and burst_req stays held.
  - If burst_req is high, mem_req is low and burst_mask != 0: latch rem_mask, base_q and we_q, clear cnt, go to BURST. No memory access occurs in this grant cycle, so dm_we = 0.
  - If burst_req is high, mem_req is low and burst_mask == 0: pulse burst_done this cycle, make no transfer, stay in IDLE.
  - With no request: dm_we = 0, dm_addr = 0, dm_wdata = 0.
- BURST, every cycle:
  - burst_idx = index of the lowest set bit of rem_mask.
  - dm_addr = base_q + cnt, modulo 2^16.
  - dm_we = we_q; dm_wdata = burst_wdata.
  - burst_ack = 1. Clear that bit of rem_mask and increment cnt.
  - mem_stall = mem_req.
  - If the cleared bit was the last set bit: burst_done = 1 in the same cycle, next state GAP.
- GAP, one cycle:
  - The MEM port is granted exactly as in IDLE.
  - burst_req is ignored even if high.
  - Next state is IDLE unconditionally. This prevents back-to-back bursts from starving the MEM stage.
- mem_stall is 1 only when mem_req = 1 and the MEM port is not granted.
- burst_ack, burst_done and burst_idx are 0 outside BURST, except for the zero-mask burst_done case in IDLE.
- All outputs are combinational from the state registers and inputs. dm_we is never 1 unless a port is granted.

## Timing
- Reset:
  - The next edge forces IDLE and clears rem_mask, base_q, we_q and cnt.
  - While reset is high, all outputs are 0, including dm_we and mem_stall.
  - Reset mid-burst abandons the burst: no burst_done and no further writes. The burst engine must re-request.
- Burst latency for N set bits, with no competing MEM request:
  - Request sampled in IDLE cycle t.
  - Transfers in cycles t+1 through t+N, with burst_done in cycle t+N.
  - GAP in cycle t+N+1, IDLE from t+N+2.
- MEM latency: 0 cycles when granted. A request made during BURST stalls for the remaining transfers and is served no later than the GAP cycle.
- LM read data returns from memory in the same cycle as burst_ack. The burst engine writes Rburst_idx with it.
- Address wrap: with base_q = 16'hFFFE, cnt 2 gives dm_addr = 16'h0000.

## Test plan
- reset high for 2 cycles with mem_req = 1 and burst_req = 1 → all outputs 0; state IDLE after release.
- burst_req, LM, mask 8'b1010_0100, base 16'h0040 → after one grant cycle, 3 acks: idx 2/5/7 at addr 0x40/0x41/0x42, dm_we = 0, done with the third ack, then GAP.
- SM, mask 8'hFF, base 16'hFFFE, with mem_req asserted from the second transfer → 8 writes at addr FFFE, FFFF, 0000 … 0005 with idx 0–7; mem_stall = 1 during the remaining transfers; MEM granted in GAP with mem_stall = 0.
- mem_req and burst_req rising in the same cycle → MEM access on dm_* with mem_stall = 0; burst granted the next cycle after mem_req drops.
- burst_req with mask 8'h00 → burst_done pulse the same cycle; no burst_ack; dm_we = 0; state stays IDLE.
- reset asserted after the 2nd of 4 transfers → no burst_done; dm_we = 0 from the reset cycle; a re-issued burst restarts at idx of the lowest mask bit and the base address.
